// File: rtl/note_player.sv
// Note RAM playback: fetches one note word per beat, decodes (string, fret)
// and drives a square-wave tone at the decoded pitch on audio_out.
module note_player #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned LAST_ADDR = 63,
  parameter int unsigned CLK_HZ    = 50000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              beat,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_q,
  output logic [31:0]       note_word,
  output logic              note_valid,
  output logic              note_active,
  output logic [2:0]        string_sel,
  output logic [2:0]        fret,
  output logic              audio_out,
  output logic              playing,
  output logic              done
);

  localparam int unsigned NUM_PITCH = 29;

  // E2 * 2^(n/12), rounded to the nearest mHz
  function automatic longint unsigned freq_mhz(input int unsigned n);
    case (n)
      0:  return 64'd82407;
      1:  return 64'd87307;
      2:  return 64'd92499;
      3:  return 64'd97999;
      4:  return 64'd103826;
      5:  return 64'd110000;
      6:  return 64'd116541;
      7:  return 64'd123471;
      8:  return 64'd130813;
      9:  return 64'd138592;
      10: return 64'd146833;
      11: return 64'd155564;
      12: return 64'd164814;
      13: return 64'd174614;
      14: return 64'd184997;
      15: return 64'd195998;
      16: return 64'd207653;
      17: return 64'd220000;
      18: return 64'd233082;
      19: return 64'd246942;
      20: return 64'd261626;
      21: return 64'd277183;
      22: return 64'd293665;
      23: return 64'd311127;
      24: return 64'd329628;
      25: return 64'd349229;
      26: return 64'd369995;
      27: return 64'd391996;
      28: return 64'd415305;
      default: return 64'd82407;
    endcase
  endfunction

  function automatic longint unsigned half_calc(input int unsigned n);
    return (64'(CLK_HZ) * 64'd1000) / (64'd2 * freq_mhz(n));
  endfunction

  // The lowest pitch has the longest half period and sets the counter width
  localparam longint unsigned HALF_MAX = half_calc(0);
  localparam int unsigned     CNT_RAW  = $clog2(HALF_MAX + 64'd1);
  localparam int unsigned     CNT_W    = (CNT_RAW > 19) ? CNT_RAW : 19;
  localparam int unsigned     TBL_W    = NUM_PITCH * CNT_W;

  function automatic logic [TBL_W-1:0] build_tbl();
    logic [TBL_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < NUM_PITCH; i++) begin
      t[i*CNT_W +: CNT_W] = CNT_W'(half_calc(i));
    end
    return t;
  endfunction

  localparam logic [TBL_W-1:0] HALF_TBL = build_tbl();

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t state, state_d;
  logic   capture, abort, finish, addr_clr, addr_inc;

  logic             dec_active;
  logic [2:0]       dec_string, dec_fret;
  logic [4:0]       dec_open, dec_pitch;
  logic [CNT_W-1:0] dec_half;
  logic [CNT_W-1:0] half_reg, tone_cnt;

  // Lowest set bit of [29:0] selects the note; the descending loop lets it win
  always_comb begin
    dec_active = |ram_q[29:0];
    dec_string = '0;
    dec_fret   = '0;
    for (int i = 29; i >= 0; i--) begin
      if (ram_q[i]) begin
        dec_string = 3'(i % 6);
        dec_fret   = 3'(i / 6);
      end
    end
    case (dec_string)
      3'd1:    dec_open = 5'd5;
      3'd2:    dec_open = 5'd10;
      3'd3:    dec_open = 5'd15;
      3'd4:    dec_open = 5'd19;
      3'd5:    dec_open = 5'd24;
      default: dec_open = 5'd0;
    endcase
    dec_pitch = dec_open + {2'b00, dec_fret};
    dec_half  = HALF_TBL[32'(dec_pitch) * CNT_W +: CNT_W];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_d;
  end

  // Next state and datapath strobes; stop overrides everything outside IDLE
  always_comb begin
    state_d  = state;
    capture  = 1'b0;
    abort    = 1'b0;
    finish   = 1'b0;
    addr_clr = 1'b0;
    addr_inc = 1'b0;
    if (state != S_IDLE && stop) begin
      state_d = S_IDLE;
      abort   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state_d  = S_ADDR;
            addr_clr = 1'b1;
          end
        end
        S_ADDR: state_d = S_READ;
        S_READ: begin
          state_d = S_HOLD;
          capture = 1'b1;
        end
        S_HOLD: begin
          if (beat) begin
            if (ram_addr == ADDR_W'(LAST_ADDR)) begin
              state_d = S_DONE;
              finish  = 1'b1;
            end else begin
              state_d  = S_ADDR;
              addr_inc = 1'b1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       ram_addr <= '0;
    else if (addr_clr) ram_addr <= '0;
    else if (addr_inc) ram_addr <= ram_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      note_word   <= '0;
      note_valid  <= 1'b0;
      note_active <= 1'b0;
      string_sel  <= '0;
      fret        <= '0;
      half_reg    <= '0;
    end else if (capture) begin
      note_word   <= ram_q;
      note_valid  <= 1'b1;
      note_active <= dec_active;
      string_sel  <= dec_string;
      fret        <= dec_fret;
      half_reg    <= dec_half;
    end else if (abort) begin
      note_valid  <= 1'b0;
      note_active <= 1'b0;
      string_sel  <= '0;
      fret        <= '0;
    end else if (finish) begin
      note_valid  <= 1'b0;
      note_active <= 1'b0;
    end
  end

  // Tone generator; every capture restarts the phase, even for a repeated note
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tone_cnt  <= '0;
      audio_out <= 1'b0;
    end else if (capture || abort || finish || !(note_valid && note_active)) begin
      tone_cnt  <= '0;
      audio_out <= 1'b0;
    end else if (tone_cnt == half_reg - CNT_W'(1)) begin
      tone_cnt  <= '0;
      audio_out <= ~audio_out;
    end else begin
      tone_cnt  <= tone_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done    <= 1'b0;
      playing <= 1'b0;
    end else begin
      done    <= finish;
      playing <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Directed and randomized checks of note_player against a pitch/decode model
// derived from the E2 * 2^(n/12) rule, with a small synchronous RAM model.
module tb_note_player;

  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned LAST_ADDR = 2;
  localparam int unsigned CLK_HZ    = 1000000;

  logic              clk = 1'b0;
  logic              resetn, start, stop, beat;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_q, note_word;
  logic              note_valid, note_active, audio_out, playing, done;
  logic [2:0]        string_sel, fret;
  logic [31:0]       mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  note_player #(
    .ADDR_W   (ADDR_W),
    .LAST_ADDR(LAST_ADDR),
    .CLK_HZ   (CLK_HZ)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .stop       (stop),
    .beat       (beat),
    .ram_addr   (ram_addr),
    .ram_q      (ram_q),
    .note_word  (note_word),
    .note_valid (note_valid),
    .note_active(note_active),
    .string_sel (string_sel),
    .fret       (fret),
    .audio_out  (audio_out),
    .playing    (playing),
    .done       (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pitch model: frequency from the semitone formula, then the half period
  function automatic int unsigned model_half(input int unsigned n);
    real f;
    longint unsigned fm;
    f  = 82407.0 * (2.0 ** (real'(n) / 12.0));
    fm = longint'($rtoi(f + 0.5));
    return int'((64'(CLK_HZ) * 64'd1000) / (64'd2 * fm));
  endfunction

  task automatic model_decode(input logic [31:0] w, output logic act,
                              output logic [2:0] s, output logic [2:0] f,
                              output int unsigned half);
    int unsigned offs [6] = '{0, 5, 10, 15, 19, 24};
    int idx;
    idx = -1;
    for (int i = 0; i < 30; i++) if (w[i] && idx < 0) idx = i;
    if (idx < 0) begin
      act = 1'b0; s = '0; f = '0; half = 0;
    end else begin
      act  = 1'b1;
      s    = 3'(idx % 6);
      f    = 3'(idx / 6);
      half = model_half(offs[idx % 6] + int'(idx / 6));
    end
  endtask

  task automatic check_note(input string tag, input logic [31:0] w,
                            input logic [ADDR_W-1:0] addr,
                            output int unsigned half, output logic act);
    logic [2:0] s, f;
    model_decode(w, act, s, f, half);
    chk({tag, ".word"},    note_word, w);
    chk({tag, ".valid"},   32'(note_valid), 32'd1);
    chk({tag, ".active"},  32'(note_active), 32'(act));
    chk({tag, ".string"},  32'(string_sel), 32'(s));
    chk({tag, ".fret"},    32'(fret), 32'(f));
    chk({tag, ".addr"},    32'(ram_addr), 32'(addr));
    chk({tag, ".playing"}, 32'(playing), 32'd1);
  endtask

  // Tone model: t edges after capture the output equals bit 0 of t/half
  task automatic tone_check(input string tag, input logic act,
                            input int unsigned half, input int unsigned cycles);
    bit seen = 1'b0;
    logic e;
    for (int unsigned t = 0; t < cycles; t++) begin
      e = 1'b0;
      if (act) e = 1'((t / half) % 2);
      if (!seen) begin
        chk(tag, 32'(audio_out), 32'(e));
        if (audio_out !== e) seen = 1'b1;
      end
      tick();
    end
  endtask

  task automatic start_play();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".word"},    note_word, 32'd0);
    chk({tag, ".valid"},   32'(note_valid), 32'd0);
    chk({tag, ".active"},  32'(note_active), 32'd0);
    chk({tag, ".string"},  32'(string_sel), 32'd0);
    chk({tag, ".fret"},    32'(fret), 32'd0);
    chk({tag, ".audio"},   32'(audio_out), 32'd0);
    chk({tag, ".playing"}, 32'(playing), 32'd0);
    chk({tag, ".done"},    32'(done), 32'd0);
    chk({tag, ".addr"},    32'(ram_addr), 32'd0);
  endtask

  task automatic chk_finish(input string tag);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    chk({tag, ".done"},    32'(done), 32'd1);
    chk({tag, ".valid"},   32'(note_valid), 32'd0);
    chk({tag, ".active"},  32'(note_active), 32'd0);
    chk({tag, ".addr"},    32'(ram_addr), 32'(LAST_ADDR));
    tick();
    chk({tag, ".done_end"},    32'(done), 32'd0);
    chk({tag, ".playing_end"}, 32'(playing), 32'd0);
    chk({tag, ".addr_end"},    32'(ram_addr), 32'(LAST_ADDR));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0:       w = {2'($urandom), 30'd0};
      1:       w = {2'($urandom), 30'd0} | (32'd1 << $urandom_range(0, 29));
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    int unsigned h;
    logic        a;
    int unsigned w;

    resetn = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    beat   = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    repeat (3) tick();
    chk_idle("rst");

    // Idle after reset release
    resetn = 1'b1;
    repeat (20) tick();
    chk_idle("idle20");

    // Basic playback, first-note latency, rest note, completion
    mem[0] = 32'h0000_0001;
    mem[1] = 32'h0000_0040;
    mem[2] = 32'h0000_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2.e0.valid", 32'(note_valid), 32'd0);
    chk("t2.e0.playing", 32'(playing), 32'd1);
    tick();
    chk("t2.e1.valid", 32'(note_valid), 32'd0);
    tick();
    check_note("t2.n0", mem[0], 0, h, a);
    tone_check("t2.n0.tone", a, h, 97);
    do_beat();
    check_note("t2.n1", mem[1], 1, h, a);
    tone_check("t2.n1.tone", a, h, 97);
    do_beat();
    check_note("t2.n2", mem[2], 2, h, a);
    tone_check("t2.n2.rest", a, h, 50);
    chk_finish("t2.fin");

    // E2 tone period, top bits ignored, then stop together with beat
    mem[0] = 32'h0000_0001;
    mem[1] = 32'hC000_0001;
    mem[2] = 32'h0000_0100;
    start_play();
    check_note("t3.n0", mem[0], 0, h, a);
    tone_check("t3.n0.tone", a, h, 2 * h + 5);
    do_beat();
    check_note("t3.n1", mem[1], 1, h, a);
    tone_check("t3.n1.tone", a, h, h + 5);
    stop = 1'b1;
    beat = 1'b1;
    tick();
    stop = 1'b0;
    beat = 1'b0;
    chk("t5.playing", 32'(playing), 32'd0);
    chk("t5.audio",   32'(audio_out), 32'd0);
    chk("t5.done",    32'(done), 32'd0);
    chk("t5.valid",   32'(note_valid), 32'd0);
    chk("t5.active",  32'(note_active), 32'd0);
    chk("t5.string",  32'(string_sel), 32'd0);
    chk("t5.fret",    32'(fret), 32'd0);
    chk("t5.addr",    32'(ram_addr), 32'd1);
    repeat (4) tick();
    chk("t5.done_later", 32'(done), 32'd0);
    chk("t5.playing_later", 32'(playing), 32'd0);

    // Start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("t6.startstop.playing", 32'(playing), 32'd0);

    // Lowest-bit priority, dropped beat in ADDR, ignored start in ADDR
    mem[0] = 32'h0004_1000;
    mem[1] = $urandom | (32'd1 << $urandom_range(0, 29));
    mem[2] = $urandom | (32'd1 << $urandom_range(0, 29));
    start_play();
    check_note("t4.n0", mem[0], 0, h, a);
    tone_check("t4.n0.tone", a, h, 20);
    beat = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    beat  = 1'b0;
    tick();
    check_note("t6.n1", mem[1], 1, h, a);
    tone_check("t6.n1.tone", a, h, 5);
    chk("t6.n1.addr_held", 32'(ram_addr), 32'd1);
    chk("t6.n1.word_held", note_word, mem[1]);
    do_beat();
    check_note("t6.n2", mem[2], 2, h, a);
    tone_check("t6.n2.tone", a, h, (h < 2500) ? h + 5 : 300);
    chk_finish("t6.fin");

    // Randomized programs against the model
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i <= int'(LAST_ADDR); i++) mem[i] = rand_word();
      start_play();
      for (int i = 0; i <= int'(LAST_ADDR); i++) begin
        check_note($sformatf("rnd%0d.n%0d", r, i), mem[i], ADDR_W'(i), h, a);
        w = 20;
        if (a) w = (h < 2500) ? h + 5 : 300;
        tone_check($sformatf("rnd%0d.n%0d.tone", r, i), a, h, w);
        if (i < int'(LAST_ADDR)) do_beat();
      end
      chk_finish($sformatf("rnd%0d.fin", r));
    end

    // Asynchronous reset in the middle of playback
    mem[0] = 32'h0000_0080;
    mem[1] = 32'h2000_0000;
    start_play();
    do_beat();
    check_note("ar.n1", mem[1], 1, h, a);
    repeat (3) tick();
    #2;
    resetn = 1'b0;
    #1;
    chk_idle("ar.async");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    chk_idle("ar.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Playback-side counterpart of the note recorder. The recorder packs strings/frets into 32-bit note words and writes one word per beat into the 64x32 note RAM.
- This block reads those words back one per beat and decodes each into (string, fret).
- It drives a square-wave tone on audio_out at the pitch of the decoded note.
- It sits between the control FSM (start/stop/beat) and the audio output pin.

Parameters:
- ADDR_W, 6, RAM address width.
- LAST_ADDR, 63, final address played before finishing.
- CLK_HZ, 50000000, clock frequency used to derive the tone half-periods.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins playback from address 0.
- stop  in  1  one-cycle pulse; aborts playback.
- beat  in  1  one-cycle tempo pulse from the clock divider.
- ram_addr  out  ADDR_W  registered read address to the note RAM.
- ram_q  in  32  RAM read data; valid one clock after ram_addr is sampled.
- note_word  out  32  last captured note word.
- note_valid  out  1  note_word holds a live note for the current beat.
- note_active  out  1  captured word has any bit of [29:0] set.
- string_sel  out  3  decoded string, 0..5.
- fret  out  3  decoded fret, 0..4 (0 = open).
- audio_out  out  1  square-wave tone.
- playing  out  1  FSM is not in IDLE.
- done  out  1  one-cycle pulse when playback completes after LAST_ADDR.

Behaviour:
- Interface: one clock, clk; reset resetn is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, ram_addr 0, tone counter 0.
- States: IDLE, ADDR, READ, HOLD, DONE.
- IDLE:
  - start && !stop -> ram_addr<=0, go to ADDR.
  - start while not in IDLE is ignored.
- ADDR: lasts one cycle; the RAM samples ram_addr at the end of it -> READ.
- READ: at the clock edge, capture the note and go to HOLD:
  - note_word<=ram_q, note_valid<=1.
  - note_active, string_sel and fret are registered from ram_q at the same edge.
- HOLD, on beat:
  - if ram_addr==LAST_ADDR -> DONE.
  - else ram_addr<=ram_addr+1 -> ADDR.
- DONE: note_valid<=0, note_active<=0, done=1 for exactly that cycle -> IDLE. ram_addr holds LAST_ADDR; there is no wrap.
- Latency:
  - start sampled at edge 0 -> note_valid high after edge 2.
  - beat in HOLD at edge k -> new note visible after edge k+2.
- A beat arriving in ADDR or READ is dropped, not queued.
- stop in any non-IDLE state, at the next edge:
  - go to IDLE.
  - note_valid, note_active, string_sel, fret and audio_out all go to 0.
  - done is not asserted.
- stop wins over a simultaneous beat or start.
- Decode:
  - idx = lowest set bit index of note_word[29:0]; string_sel = idx mod 6, fret = idx / 6.
  - Bits [31:30] are ignored.
  - An all-zero [29:0] is a rest: note_active=0, string_sel=0, fret=0.
- Pitch:
  - String open-note semitone offsets from E2, strings 0..5: 0, 5, 10, 15, 19, 24.
  - n = offset + fret, range 0..28.
  - freq = 82.407 Hz * 2^(n/12), held as a 29-entry table in mHz.
  - half_period = CLK_HZ*1000 / (2*freq_mHz), truncating integer division, computed at elaboration.
  - Default-clock values: n=0 -> 303372; n=5 (110000 mHz) -> 227272. The counter is 19 bits minimum.
- Tone:
  - On every note capture, the counter resets to 0 and audio_out resets to 0; phase restarts even for a repeated note.
  - While note_valid && note_active, the counter increments each cycle. At half_period-1 it wraps to 0 and audio_out toggles.
  - Otherwise the counter and audio_out are held at 0.
- Asserting resetn mid-playback returns all state and outputs to their reset values immediately, without waiting for clk.

Test Plan:
1. Reset, then release; no stimulus for 20 cycles -> all outputs 0, playing=0.
2. RAM[0]=0x00000001, RAM[1]=0x00000040, RAM[2]=0; pulse start, then beat every 100 cycles:
   - note_valid high 2 cycles after start; string_sel/fret = 0/0.
   - After the first beat: string_sel=0, fret=1.
   - After the second beat: note_active=0 and audio_out stays 0.
3. CLK_HZ=1000000, RAM[0]=0x00000001 (E2, half_period=6067):
   - audio_out toggles every 6067 cycles.
   - Bits [31:30] set on the same word -> identical tone.
4. Word 0x00041000 (bits 12 and 18) -> string_sel=0, fret=2 (lowest bit wins).
5. stop asserted in HOLD together with beat:
   - Next cycle: IDLE, audio_out=0, done=0.
   - ram_addr does not advance.
6. LAST_ADDR=2, three beats after start:
   - done pulses for one cycle after the third beat; playing=0.
   - A start pulse issued during ADDR is ignored.
